video_frame_grabber: RTL and testbench

Captures one complete video frame from the synchronous video stream (vid_active/vid_hsync/vid_vsync/vid_r/g/b) and writes it, pixel by pixel, into a video memory write port in RGB332 format. It is the receive-side counterpart of video_pipe_sync_top. Its write port connects directly to the vram write interface (vram_adr_w/vram_dat_w/vram_we), enabling loopback checks and screen capture in hardware.

---
 rtl/video_frame_grabber_if.sv | 12 +
 rtl/video_frame_grabber.sv | 138 +++++++++++++
 tb/tb_video_frame_grabber.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/video_frame_grabber_if.sv
// Memory write port between the frame grabber (master) and a vram write port (slave).
interface video_frame_grabber_if #(
  parameter int MAW = 19,
  parameter int MDW = 8
);
  logic           mem_we;
  logic [MAW-1:0] mem_adr;
  logic [MDW-1:0] mem_dat;

  modport master (output mem_we, mem_adr, mem_dat);
  modport slave  (input  mem_we, mem_adr, mem_dat);
endinterface

// File: rtl/video_frame_grabber.sv
// Captures one full video frame from a sync/active stream and writes it as RGB332
// pixels, in raster order, to a vram write port.
module video_frame_grabber #(
  parameter int   WIDTH  = 640,
  parameter int   HEIGHT = 480,
  parameter int   CCW    = 8,
  parameter int   MAW    = 19,
  parameter int   MDW    = 8,
  parameter logic VS_POL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        arm,
  input  logic                        vid_active,
  input  logic                        vid_hsync,
  input  logic                        vid_vsync,
  input  logic [CCW-1:0]              vid_r,
  input  logic [CCW-1:0]              vid_g,
  input  logic [CCW-1:0]              vid_b,
  video_frame_grabber_if.master       wr,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  err
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(HEIGHT + 1);

  typedef enum logic [1:0] {IDLE, ARMED, SYNC, CAPTURE} state_t;

  state_t         state, state_n;
  logic [MAW-1:0] adr, adr_n, madr_n;
  logic [CW-1:0]  col, col_n;
  logic [LW-1:0]  line, line_n;
  logic [MDW-1:0] mdat_n;
  logic [1:0]     err_n;
  logic           last, last_n, busy_n, done_n, we_n;
  logic           vs_q, act_q;
  logic           vs_lead, vs_trail;
  logic [7:0]     pix;
  logic           unused_bits;

  assign vs_lead     = (vid_vsync == VS_POL) && (vs_q != VS_POL);
  assign vs_trail    = (vid_vsync != VS_POL) && (vs_q == VS_POL);
  assign pix         = {vid_r[CCW-1-:3], vid_g[CCW-1-:3], vid_b[CCW-1-:2]};
  assign unused_bits = ^{vid_hsync, vid_r, vid_g, vid_b, line};

  always_comb begin
    state_n = state;
    adr_n   = adr;
    col_n   = col;
    line_n  = line;
    last_n  = last;
    err_n   = err;
    busy_n  = busy;
    done_n  = 1'b0;
    we_n    = 1'b0;
    madr_n  = wr.mem_adr;
    mdat_n  = wr.mem_dat;
    case (state)
      IDLE: if (arm) begin
        state_n = ARMED;
        err_n   = 2'b00;
        busy_n  = 1'b1;
      end
      ARMED: if (vs_lead) state_n = SYNC;
      SYNC: if (vs_trail) begin
        state_n = CAPTURE;
        adr_n   = '0;
        col_n   = '0;
        line_n  = '0;
        last_n  = 1'b0;
      end
      CAPTURE: begin
        // Completion is checked before the vsync edge so a coincident edge is not an abort.
        if (last) begin
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
        end else if (vs_lead) begin
          state_n  = IDLE;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          err_n[1] = 1'b1;
        end else if (vid_active) begin
          if (col < CW'(WIDTH)) begin
            we_n   = 1'b1;
            madr_n = adr;
            mdat_n = pix;
            adr_n  = adr + 1'b1;
            col_n  = col + 1'b1;
            last_n = (adr == MAW'(N - 1));
          end else begin
            err_n[0] = 1'b1;
          end
        end else if (act_q) begin
          if (col != CW'(WIDTH)) err_n[0] = 1'b1;
          line_n = line + 1'b1;
          col_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      adr        <= '0;
      col        <= '0;
      line       <= '0;
      last       <= 1'b0;
      err        <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      vs_q       <= ~VS_POL;
      act_q      <= 1'b0;
      wr.mem_we  <= 1'b0;
      wr.mem_adr <= '0;
      wr.mem_dat <= '0;
    end else if (clk_en) begin
      state      <= state_n;
      adr        <= adr_n;
      col        <= col_n;
      line       <= line_n;
      last       <= last_n;
      err        <= err_n;
      busy       <= busy_n;
      done       <= done_n;
      vs_q       <= vid_vsync;
      act_q      <= vid_active;
      wr.mem_we  <= we_n;
      wr.mem_adr <= madr_n;
      wr.mem_dat <= mdat_n;
    end
  end
endmodule

// File: tb/tb_video_frame_grabber.sv
// Randomized frame-capture bench: a frame-level model predicts the write stream and done/err,
// and a monitor compares every enabled-cycle output against the queued expectations.
module tb_video_frame_grabber;
  localparam int   WIDTH  = 8;
  localparam int   HEIGHT = 4;
  localparam int   CCW    = 8;
  localparam int   MAW    = 6;
  localparam int   N      = WIDTH * HEIGHT;
  localparam logic VS_POL = 1'b0;

  logic clk = 1'b0;
  logic rst, clk_en, arm, vid_active, vid_hsync, vid_vsync;
  logic [CCW-1:0] vid_r, vid_g, vid_b;
  logic busy, done;
  logic [1:0] err;

  video_frame_grabber_if #(.MAW(MAW), .MDW(8)) vif ();

  video_frame_grabber #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CCW(CCW), .MAW(MAW), .MDW(8), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .arm(arm),
    .vid_active(vid_active), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .wr(vif), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_mode = 0;
  bit tog = 1'b0;
  logic [MAW+7:0] wq[$];
  logic [1:0]     dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: judges outputs only after enabled, non-reset edges.
  logic           en_s, rst_s;
  logic [MAW+7:0] we_exp;
  logic [1:0]     de_exp;
  always @(posedge clk) begin
    en_s  = clk_en;
    rst_s = rst;
    #1;
    if (en_s && !rst_s) begin
      if (vif.mem_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL write: unexpected write adr %0d dat %0h, none expected", vif.mem_adr, vif.mem_dat);
        end else begin
          we_exp = wq.pop_front();
          chk("write_adr", 32'(vif.mem_adr), 32'(we_exp[MAW+7:8]));
          chk("write_dat", 32'(vif.mem_dat), 32'(we_exp[7:0]));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done: unexpected done pulse, err %0h", err);
        end else begin
          de_exp = dq.pop_front();
          chk("done_err", 32'(err), 32'(de_exp));
          chk("done_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  // One enabled clock; inputs are changed on the falling edge only.
  task automatic step();
    bit e;
    int tries = 0;
    do begin
      if (en_mode == 0) e = 1'b1;
      else if (en_mode == 1) begin tog = ~tog; e = tog; end
      else e = 1'($urandom_range(0, 1));
      clk_en = e;
      @(posedge clk);
      @(negedge clk);
      tries++;
    end while (!e && tries < 64);
    if (!e) begin
      checks++; errors++;
      $display("FAIL step_timeout: clk_en low for %0d cycles, required high within 64", tries);
    end
  endtask

  task automatic blank(input int n);
    vid_active = 1'b0;
    vid_hsync  = 1'b1;
    repeat (n) step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("busy_after_arm", 32'(busy), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  // One frame: vsync pulse, back porch, nlines lines. If cap, the grabber is expected to
  // be armed and the frame's first N accepted pixels form the expected write stream.
  task automatic frame(input int nlines, input int short_ln, input bit cap,
                       input int arm_ln, input int rst_ln);
    int written = 0;
    logic [1:0] errm = 2'b00;
    bit live = cap;
    int len;
    logic [7:0] dat;
    vid_active = 1'b0;
    vid_vsync  = VS_POL;
    repeat (3) step();
    vid_vsync  = ~VS_POL;
    blank(2);
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_ln) ? WIDTH - 1 : WIDTH;
      for (int p = 0; p < len; p++) begin
        {vid_r, vid_g, vid_b} = 24'($urandom);
        vid_active = 1'b1;
        vid_hsync  = 1'b0;
        arm = (l == arm_ln) && (p == 0);
        rst = (l == rst_ln) && (p == 3);
        dat = {vid_r[7:5], vid_g[7:5], vid_b[7:6]};
        if (rst) live = 1'b0;
        else if (live && written < N) begin
          wq.push_back({MAW'(written), dat});
          written++;
          if (written == N) dq.push_back(errm);
        end
        step();
        arm = 1'b0;
        if (l == rst_ln && p == 3) begin
          rst = 1'b0;
          chk("rst_mem_we", 32'(vif.mem_we), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
        end
      end
      if (live && written < N && len != WIDTH) errm[0] = 1'b1;
      blank(3);
    end
    if (live && written < N) dq.push_back(errm | 2'b10);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; arm = 1'b0;
    vid_active = 1'b0; vid_hsync = 1'b1; vid_vsync = ~VS_POL;
    vid_r = '0; vid_g = '0; vid_b = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("reset_mem_we", 32'(vif.mem_we), 32'd0);
    chk("reset_mem_adr", 32'(vif.mem_adr), 32'd0);
    chk("reset_mem_dat", 32'(vif.mem_dat), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    blank(2);

    // nominal frame; the arm during line 1 must be ignored
    do_arm();
    frame(HEIGHT, -1, 1'b1, 1, -1);
    // arm mid-frame: that frame is skipped, the next one captured
    frame(HEIGHT, -1, 1'b0, 2, -1);
    frame(HEIGHT, -1, 1'b1, -1, -1);
    // short line 1, an extra line lets the capture complete
    do_arm();
    frame(HEIGHT + 1, 1, 1'b1, -1, -1);
    // early vsync after 2 lines aborts at the next frame start
    do_arm();
    frame(2, -1, 1'b1, -1, -1);
    frame(HEIGHT, -1, 1'b0, -1, -1);
    chk("err_sticky", 32'(err), 32'd2);
    // alternating and random clock enable
    en_mode = 1;
    do_arm();
    frame(HEIGHT, -1, 1'b1, -1, -1);
    en_mode = 2;
    do_arm();
    frame(HEIGHT, -1, 1'b1, -1, -1);
    // reset during line 1, then a fresh capture
    en_mode = 0;
    do_arm();
    frame(HEIGHT, -1, 1'b1, -1, 1);
    blank(2);
    do_arm();
    frame(HEIGHT, -1, 1'b1, -1, -1);
    blank(4);
    chk("writes_pending", 32'(wq.size()), 32'd0);
    chk("done_pending", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
